// File: rtl/axi_bw_responder.sv
// axi_bw_responder: target-side write-response generator.
// Queues the ID/USER of every accepted AW burst, records one error flag per
// completed W burst, and returns in-order B responses toward the node.
module axi_bw_responder #(
    parameter int AXI_ID_W   = 16,
    parameter int AXI_USER_W = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AXI_ID_W-1:0]   awid_i,
    input  logic [AXI_USER_W-1:0] awuser_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic                  wlast_i,
    input  logic                  werr_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [AXI_ID_W-1:0]   bid_o,
    output logic [1:0]            bresp_o,
    output logic [AXI_USER_W-1:0] buser_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  outstanding_o,
    output logic                  full_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Header storage and per-burst error flags; both queues share one read
    // pointer because a B handshake always retires one entry from each.
    logic [AXI_ID_W-1:0]   id_mem   [FIFO_DEPTH];
    logic [AXI_USER_W-1:0] user_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_mem;

    logic [PTR_W-1:0] aw_wr_ptr;
    logic [PTR_W-1:0] cmp_wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] aw_cnt;
    logic [CNT_W-1:0] cmp_cnt;
    logic [CNT_W-1:0] aw_cnt_next;
    logic [CNT_W-1:0] cmp_cnt_next;
    logic             err_acc;

    logic aw_push;
    logic w_accept;
    logic cmp_push;
    logic b_pop;

    // Handshakes and ready/valid are all derived from registered counters only.
    assign awready_o     = (aw_cnt != DEPTH_CNT);
    assign wready_o      = (cmp_cnt < aw_cnt);
    assign bvalid_o      = (cmp_cnt != '0);
    assign outstanding_o = (aw_cnt != '0);
    assign full_o        = (aw_cnt == DEPTH_CNT);

    assign aw_push  = awvalid_i & awready_o;
    assign w_accept = wvalid_i & wready_o;
    assign cmp_push = w_accept & wlast_i;
    assign b_pop    = bvalid_o & bready_i;

    assign bid_o   = id_mem[rd_ptr];
    assign buser_o = user_mem[rd_ptr];
    assign bresp_o = err_mem[rd_ptr] ? 2'b10 : 2'b00;

    // Counter updates: simultaneous push and pop leave a counter unchanged.
    always_comb begin
        aw_cnt_next  = aw_cnt;
        cmp_cnt_next = cmp_cnt;
        case ({aw_push, b_pop})
            2'b10:   aw_cnt_next = aw_cnt + CNT_ONE;
            2'b01:   aw_cnt_next = aw_cnt - CNT_ONE;
            default: aw_cnt_next = aw_cnt;
        endcase
        case ({cmp_push, b_pop})
            2'b10:   cmp_cnt_next = cmp_cnt + CNT_ONE;
            2'b01:   cmp_cnt_next = cmp_cnt - CNT_ONE;
            default: cmp_cnt_next = cmp_cnt;
        endcase
    end

    // Pointers, counters and the running error accumulator of the open burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wr_ptr  <= '0;
            cmp_wr_ptr <= '0;
            rd_ptr     <= '0;
            aw_cnt     <= '0;
            cmp_cnt    <= '0;
            err_acc    <= 1'b0;
        end else begin
            aw_cnt  <= aw_cnt_next;
            cmp_cnt <= cmp_cnt_next;
            if (aw_push) begin
                aw_wr_ptr <= aw_wr_ptr + PTR_ONE;
            end
            if (cmp_push) begin
                cmp_wr_ptr <= cmp_wr_ptr + PTR_ONE;
            end
            if (b_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (w_accept) begin
                err_acc <= wlast_i ? 1'b0 : (err_acc | werr_i);
            end
        end
    end

    // Queue storage; cleared on reset so B fields read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                id_mem[i]   <= '0;
                user_mem[i] <= '0;
            end
            err_mem <= '0;
        end else begin
            if (aw_push) begin
                id_mem[aw_wr_ptr]   <= awid_i;
                user_mem[aw_wr_ptr] <= awuser_i;
            end
            if (cmp_push) begin
                err_mem[cmp_wr_ptr] <= err_acc | werr_i;
            end
        end
    end

endmodule

// File: tb/tb_axi_bw_responder.sv
// tb_axi_bw_responder: directed self-checking bench for axi_bw_responder.
// Inputs are driven 1 ns after each rising edge and outputs are sampled there.
module tb_axi_bw_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] awid;
    logic [5:0]  awuser;
    logic        awvalid;
    logic        awready;
    logic        wlast;
    logic        werr;
    logic        wvalid;
    logic        wready;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic [5:0]  buser;
    logic        bvalid;
    logic        bready;
    logic        outstanding;
    logic        full;

    int compared   = 0;
    int mismatched = 0;

    axi_bw_responder #(
        .AXI_ID_W  (16),
        .AXI_USER_W(6),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .awid_i       (awid),
        .awuser_i     (awuser),
        .awvalid_i    (awvalid),
        .awready_o    (awready),
        .wlast_i      (wlast),
        .werr_i       (werr),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .bid_o        (bid),
        .bresp_o      (bresp),
        .buser_o      (buser),
        .bvalid_o     (bvalid),
        .bready_i     (bready),
        .outstanding_o(outstanding),
        .full_o       (full)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        awid    = '0;
        awuser  = '0;
        awvalid = 1'b0;
        wlast   = 1'b0;
        werr    = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        compared++;
        if (awready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_awready got %b want 1", awready); end
        compared++;
        if (wready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wready got %b want 0", wready); end
        compared++;
        if (bvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bvalid got %b want 0", bvalid); end
        compared++;
        if ({bid, bresp, buser} !== 24'h0) begin mismatched++; $display("[TB] FAIL reset_bfields got %h/%b/%h want 0", bid, bresp, buser); end
        compared++;
        if ({outstanding, full} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_flags got %b%b want 00", outstanding, full); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_burst();
        bready  = 1'b1;
        awid    = 16'h1234;
        awuser  = 6'h05;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        compared++;
        if (wready !== 1'b1) begin mismatched++; $display("[TB] FAIL single_wready got %b want 1", wready); end
        for (int beat = 0; beat < 4; beat++) begin
            wvalid = 1'b1;
            wlast  = (beat == 3);
            if (beat == 3) begin
                compared++;
                if (bvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early_bvalid got %b want 0", bvalid); end
            end
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'h1234 || buser !== 6'h05 || bresp !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL single_b got v=%b id=%h user=%h resp=%b want v=1 id=1234 user=05 resp=00", bvalid, bid, buser, bresp);
        end
        step();
        compared++;
        if (bvalid !== 1'b0 || outstanding !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_after got v=%b outstanding=%b want 0 0", bvalid, outstanding);
        end
        bready = 1'b0;
    endtask

    task automatic test_error_isolation();
        bready  = 1'b0;
        awvalid = 1'b1;
        awid    = 16'd1;
        awuser  = 6'h11;
        step();
        awid    = 16'd2;
        awuser  = 6'h22;
        step();
        awvalid = 1'b0;
        for (int beat = 0; beat < 6; beat++) begin
            wvalid = 1'b1;
            werr   = (beat == 1);
            wlast  = (beat == 2) || (beat == 5);
            step();
        end
        wvalid = 1'b0;
        werr   = 1'b0;
        wlast  = 1'b0;
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'd1 || bresp !== 2'b10 || buser !== 6'h11) begin
            mismatched++;
            $display("[TB] FAIL errA_b got v=%b id=%h resp=%b user=%h want 1 0001 10 11", bvalid, bid, bresp, buser);
        end
        bready = 1'b1;
        step();
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'd2 || bresp !== 2'b00 || buser !== 6'h22) begin
            mismatched++;
            $display("[TB] FAIL errB_b got v=%b id=%h resp=%b user=%h want 1 0002 00 22", bvalid, bid, bresp, buser);
        end
        step();
        compared++;
        if (bvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL err_drained got %b want 0", bvalid); end
        bready = 1'b0;
    endtask

    task automatic test_full_queue();
        int accepted;
        int got_ids[$];
        accepted = 0;
        bready   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            awid    = 16'(i);
            awvalid = 1'b1;
            if (awready === 1'b1) accepted++;
            step();
            if (awready !== 1'b1) break;
        end
        // The id=4 request stays presented while the queue is full.
        awid = 16'd4;
        compared++;
        if (accepted != 4) begin mismatched++; $display("[TB] FAIL full_accepted got %0d want 4", accepted); end
        compared++;
        if (full !== 1'b1 || awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_state got full=%b awready=%b wready=%b bvalid=%b want 1 0 1 0", full, awready, wready, bvalid);
        end
        wvalid = 1'b1;
        wlast  = 1'b1;
        step();
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'd0 || awready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_pop_cycle got bvalid=%b bid=%h awready=%b want 1 0000 0", bvalid, bid, awready);
        end
        step();
        bready = 1'b0;
        compared++;
        if (awready !== 1'b1) begin mismatched++; $display("[TB] FAIL full_awready_after_pop got %b want 1", awready); end
        step();
        awvalid = 1'b0;
        compared++;
        if (full !== 1'b1) begin mismatched++; $display("[TB] FAIL full_id4_accepted got full=%b want 1", full); end
        // Drain the four remaining bursts and record the B order.
        wvalid = 1'b1;
        wlast  = 1'b1;
        bready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bvalid === 1'b1) got_ids.push_back(int'(bid));
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b0;
        compared++;
        if (got_ids.size() != 4 || got_ids[0] != 1 || got_ids[1] != 2 || got_ids[2] != 3 || got_ids[3] != 4) begin
            mismatched++;
            $display("[TB] FAIL full_drain_order got %p want '{1,2,3,4}", got_ids);
        end
    endtask

    task automatic test_backpressure();
        int unstable;
        logic [15:0] exp_id [3];
        logic [1:0]  exp_resp [3];
        exp_id   = '{16'd7, 16'd8, 16'd9};
        exp_resp = '{2'b00, 2'b10, 2'b00};
        unstable = 0;
        bready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            awid    = exp_id[i];
            awvalid = 1'b1;
            step();
        end
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1;
            wlast  = 1'b1;
            werr   = (i == 1);
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        werr   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bvalid !== 1'b1 || bid !== 16'd7 || bresp !== 2'b00) unstable++;
            step();
        end
        compared++;
        if (unstable != 0) begin mismatched++; $display("[TB] FAIL bp_hold got %0d unstable cycles want 0", unstable); end
        bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (bvalid !== 1'b1 || bid !== exp_id[i] || bresp !== exp_resp[i]) begin
                mismatched++;
                $display("[TB] FAIL bp_release%0d got v=%b id=%h resp=%b want 1 %h %b", i, bvalid, bid, bresp, exp_id[i], exp_resp[i]);
            end
            step();
        end
        compared++;
        if (bvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_empty got %b want 0", bvalid); end
        bready = 1'b0;
    endtask

    task automatic test_simultaneous();
        bready  = 1'b0;
        awvalid = 1'b1;
        awid    = 16'h000A;
        awuser  = 6'h0A;
        step();
        awid    = 16'h000B;
        awuser  = 6'h0B;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b1;
        wlast   = 1'b1;
        step();
        // aw_cnt=2, cmp_cnt=1: push AW, complete burst B and pop A together.
        awvalid = 1'b1;
        awid    = 16'h000C;
        awuser  = 6'h0C;
        bready  = 1'b1;
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'h000A || wready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL simul_setup got v=%b id=%h wready=%b want 1 000a 1", bvalid, bid, wready);
        end
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'h000B || buser !== 6'h0B || wready !== 1'b1 || full !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL simul_counts got v=%b id=%h user=%h wready=%b full=%b want 1 000b 0b 1 0", bvalid, bid, buser, wready, full);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        compared++;
        if (bvalid !== 1'b0 || outstanding !== 1'b1 || wready !== 1'b1 || bid !== 16'h000C) begin
            mismatched++;
            $display("[TB] FAIL simul_after got v=%b outstanding=%b wready=%b id=%h want 0 1 1 000c", bvalid, outstanding, wready, bid);
        end
    endtask

    task automatic test_reset_mid_burst();
        int stale;
        stale   = 0;
        bready  = 1'b0;
        awvalid = 1'b1;
        awid    = 16'h0011;
        awuser  = 6'h01;
        step();
        awid    = 16'h0022;
        awuser  = 6'h02;
        step();
        awvalid = 1'b0;
        for (int beat = 0; beat < 2; beat++) begin
            wvalid = 1'b1;
            wlast  = 1'b0;
            werr   = 1'b1;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || outstanding !== 1'b0 || full !== 1'b0 ||
            {bid, bresp, buser} !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs got awr=%b wr=%b bv=%b out=%b full=%b b=%h/%b/%h want 1 0 0 0 0 0/0/0",
                     awready, wready, bvalid, outstanding, full, bid, bresp, buser);
        end
        wvalid = 1'b1;
        wlast  = 1'b1;
        werr   = 1'b0;
        bready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (bvalid !== 1'b0 || outstanding !== 1'b0 || wready !== 1'b0) stale++;
            step();
        end
        compared++;
        if (stale != 0) begin mismatched++; $display("[TB] FAIL midreset_stale got %0d bad cycles want 0", stale); end
        // A fresh clean burst must not inherit the pre-reset error.
        awvalid = 1'b1;
        awid    = 16'h0033;
        awuser  = 6'h03;
        bready  = 1'b0;
        step();
        awvalid = 1'b0;
        step();
        wvalid = 1'b0;
        wlast  = 1'b0;
        compared++;
        if (bvalid !== 1'b1 || bid !== 16'h0033 || bresp !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL midreset_fresh got v=%b id=%h resp=%b want 1 0033 00", bvalid, bid, bresp);
        end
    endtask

    // Run every scenario in order, resetting between them.
    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        do_reset();
        test_single_burst();
        do_reset();
        test_error_isolation();
        do_reset();
        test_full_queue();
        do_reset();
        test_backpressure();
        do_reset();
        test_simultaneous();
        do_reset();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_bw_responder.md
# axi_bw_responder

Target-side write-response generator for the AXI node. Accepts AW headers and W beats destined for a local slave, queues the ID/USER of every accepted burst, and drives the B channel (`bid_o`/`bresp_o`/`buser_o`/`bvalid_o`) back toward the node's backward-write arbitration, one response per completed burst, in order. It is the producer of the responses that the node's B-channel allocator merges.

## Interface
- `AXI_ID_W`, default 16: width of the AW and B ID fields.
- `AXI_USER_W`, default 6: width of the AW and B USER fields.
- `FIFO_DEPTH`, default 4: outstanding bursts held. Power of two, ≥2.

Ports:
- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `awid_i`  in  AXI_ID_W  write burst ID.
- `awuser_i`  in  AXI_USER_W  write burst USER.
- `awvalid_i`  in  1  AW valid.
- `awready_o`  out  1  AW ready.
- `wlast_i`  in  1  last beat of the current burst.
- `werr_i`  in  1  slave error flag for this beat.
- `wvalid_i`  in  1  W valid.
- `wready_o`  out  1  W ready.
- `bid_o`  out  AXI_ID_W  response ID.
- `bresp_o`  out  2  response code: 2'b00 OKAY, 2'b10 SLVERR.
- `buser_o`  out  AXI_USER_W  response USER.
- `bvalid_o`  out  1  B valid.
- `bready_i`  in  1  B ready.
- `outstanding_o`  out  1  at least one burst has been accepted whose response has not yet been handshaken.
- `full_o`  out  1  AW queue full.

## Operation
- **AW queue:** circular buffer of `{awid, awuser}` with FIFO_DEPTH entries and counter `aw_cnt` (0..FIFO_DEPTH).
  - Push on `awvalid_i & awready_o`.
  - `awready_o = (aw_cnt != FIFO_DEPTH)`. There is no same-cycle pop bypass.
- **Completion queue:** 1-bit error flag per completed burst, FIFO_DEPTH entries, counter `cmp_cnt` (0..aw_cnt).
  - Push on `wvalid_i & wready_o & wlast_i`.
  - Pushed value is `err_acc | werr_i`.
- **Error accumulator `err_acc`:**
  - Sets on any accepted beat with `werr_i = 1`.
  - Clears on an accepted `wlast_i` beat, so a burst's error never leaks into the next burst.
- **W acceptance:** `wready_o = (cmp_cnt < aw_cnt)`. W beats are accepted only while some queued AW still has an incomplete data burst.
- **B output:**
  - `bvalid_o = (cmp_cnt != 0)`.
  - `bid_o` and `buser_o` come from the AW queue head.
  - `bresp_o = head_err ? 2'b10 : 2'b00`.
  - On `bvalid_o & bready_i`, pop both queues.
- **Simultaneous events:**
  - AW push and B pop in the same cycle: `aw_cnt` unchanged.
  - wlast push and B pop in the same cycle: `cmp_cnt` unchanged.
  - All of AW push, wlast push and B pop in the same cycle: both counters unchanged.
- **Status flags:** `outstanding_o = (aw_cnt != 0)`; `full_o = (aw_cnt == FIFO_DEPTH)`.
- **Pointers:** read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty is decided by the counters only.

## Timing
- **Reset** (asynchronous, any cycle including mid-burst):
  - Counters, pointers, `err_acc` and storage go to 0.
  - Outputs: `awready_o = 1`, `wready_o = 0`, `bvalid_o = 0`, `bid_o = 0`, `bresp_o = 0`, `buser_o = 0`, `outstanding_o = 0`, `full_o = 0`.
  - All in-flight bursts are discarded and no B is issued for them.
- **AW to W:** an AW accepted at cycle N makes `wready_o` high no earlier than cycle N+1. A W beat presented alongside its own AW waits one cycle.
- **wlast to B:** a wlast handshake at cycle N gives `bvalid_o = 1` at cycle N+1.
- **B throughput:** one B per cycle when `bready_i` is held high.
- **B stability:** while `bvalid_o & !bready_i`, `bid_o`, `bresp_o` and `buser_o` hold stable. `bvalid_o` never drops without a handshake.
- **Ordering:** responses leave in AW-acceptance order. There is no ID-based reordering.
- **Full AW queue:** with `aw_cnt = FIFO_DEPTH`, `awready_o = 0` in the same cycle as a B pop. `awready_o` rises the cycle after the pop.
- **Combinational paths:** `awready_o`, `wready_o` and `bvalid_o` depend only on registered state; none depends combinationally on any valid or ready input.

## Test plan
- **Single burst:**
  - Stimulus: AW id=0x1234, user=0x05; then 4 W beats with no error (last beat wlast=1); `bready_i = 1`.
  - Required: `bvalid_o` rises exactly 1 cycle after the wlast handshake with bid=0x1234, buser=0x05, bresp=2'b00. After the B handshake, `outstanding_o` returns to 0.
- **Error isolation:**
  - Stimulus: burst A (id=1) with `werr_i = 1` on beat 2 of 3, followed immediately by burst B (id=2) with no errors.
  - Required: B responses in order: id=1 bresp=2'b10, then id=2 bresp=2'b00.
- **Full queue:**
  - Stimulus: 5 back-to-back AWs (ids 0..4) with FIFO_DEPTH=4 and `wvalid_i = 0`.
  - Required: 4 AWs accepted, `full_o = 1`, `awready_o = 0`, `wready_o = 1`, `bvalid_o = 0`.
  - Then: complete 1 burst and handshake its B. Required: `awready_o` returns to 1 the next cycle and id=4 is accepted.
- **B backpressure:**
  - Stimulus: 3 single-beat bursts (ids 7, 8, 9) with `bready_i = 0` for 10 cycles.
  - Required: `bvalid_o = 1` with bid=7 held stable throughout. On release, bids 7, 8, 9 appear on 3 consecutive cycles.
- **Simultaneous events:**
  - Stimulus: AW push, wlast push and B pop all in the same cycle, with aw_cnt=2 and cmp_cnt=1.
  - Required: both counters stay unchanged, so the next B is present the following cycle.
- **Reset mid-burst:**
  - Stimulus: assert `rst_n = 0` after 2 of 4 beats of a burst with 2 AWs queued.
  - Required: all outputs are at reset values immediately, and no stale B is issued after reset release.
